barrel_shifter: RTL and testbench
=================================

BARREL_SHIFTER -- requirements
Module: barrel_shifter

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; SHALL be a power of two, >= 2.
REQ-002 Parameter SHW, default 3, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for the output register.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in  input  WIDTH  data word to be shifted.
REQ-007 shamt  input  SHW  unsigned shift distance, 0..WIDTH-1.
REQ-008 dir  input  1  direction: 1 = left (toward MSB), 0 = right (toward LSB).
REQ-009 out  output  WIDTH  registered shift result.

Function
REQ-010 Shift type SHALL be logical; vacated bit positions SHALL be filled with 0; no rotate; no sign extension.
REQ-011 dir=1: next out SHALL equal (in << shamt) truncated to WIDTH bits; bits shifted past the MSB are discarded.
REQ-012 dir=0: next out SHALL equal in >> shamt; bits shifted past the LSB are discarded.
REQ-013 shamt=0 SHALL pass in through unchanged for either value of dir.
REQ-014 Datapath SHALL be SHW cascaded mux stages; stage k shifts by 2^k when shamt[k]=1, else passes through; direction applied at every stage.
REQ-015 Shift logic SHALL be combinational from in/shamt/dir to the output register D input; no internal state other than out.
REQ-016 out SHALL update on every rising clk edge while rst_n=1, with no enable; latency exactly 1 cycle from inputs to out.
REQ-017 Inputs SHALL be sampled only at the rising clk edge; input changes between edges SHALL NOT affect out until the next edge.
REQ-018 Every combination of in, shamt and dir SHALL be legal; there are no illegal or unused codes.
REQ-019 shamt=WIDTH-1 SHALL leave exactly one surviving input bit (in[0] at MSB for left, in[WIDTH-1] at LSB for right).
REQ-020 No X propagation: for known inputs, out SHALL be fully known after the first clock edge following reset release.

Reset
REQ-021 rst_n=0 SHALL force out to all zeros immediately, independent of clk.
REQ-022 While rst_n=0, out SHALL hold zero regardless of clock edges or input changes.
REQ-023 After rst_n rises, the first rising clk edge SHALL load the shift result of the inputs present at that edge.
REQ-024 Reset asserted mid-stream SHALL discard the pending result; no previous value is restored after release.

Verification
REQ-025 Reset: rst_n=0 with in=0xFF, dir=0, shamt=0 and clk toggling -> out=0x00 throughout.
REQ-026 Left sweep, in=0x66, dir=1, shamt 0..7 one per cycle -> out 0x66, 0xCC, 0x98, 0x30, 0x60, 0xC0, 0x80, 0x00, each one cycle after its stimulus.
REQ-027 Right sweep, in=0xFF, dir=0, shamt 0..7 -> out 0xFF, 0x7F, 0x3F, 0x1F, 0x0F, 0x07, 0x03, 0x01.
REQ-028 Zero input, in=0x00, any dir and shamt -> out=0x00.
REQ-029 Single-bit walk, in=0x01, dir=1, shamt=7 -> 0x80; in=0x80, dir=0, shamt=7 -> 0x01; in=0x80, dir=1, shamt=1 -> 0x00.
REQ-030 Mid-run reset: assert rst_n=0 asynchronously between edges during the REQ-026 sweep -> out=0x00 at once; after release, the first edge resumes the correct sweep value.

Source files
------------

// File: rtl/barrel_shifter.sv
// Logical barrel shifter, left or right, with a registered output.
// One mux stage per shift-amount bit; out is cleared by async reset.
module barrel_shifter #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic [SHW-1:0]   shamt,
   input  logic             dir,
   output logic [WIDTH-1:0] out
);

   logic [SHW:0][WIDTH-1:0] stg;

   assign stg[0] = in;

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int DIST = 1 << k;

      // stage k shifts by 2^k toward MSB or LSB when its shamt bit is set
      always_comb begin
         stg[k+1] = stg[k];
         if (shamt[k]) begin
            if (dir) stg[k+1] = stg[k] << DIST;
            else     stg[k+1] = stg[k] >> DIST;
         end
      end
   end

   // capture the shift result every edge; reset clears it immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out <= '0;
      else        out <= stg[SHW];
   end

endmodule

// File: tb/tb_barrel_shifter.sv
// Scoreboard bench for barrel_shifter: a driver queues expected results,
// a monitor pops and compares them one cycle later.
module tb_barrel_shifter;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] in    = 8'h00;
   logic [2:0] shamt = 3'd0;
   logic       dir   = 1'b0;
   logic [7:0] out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] expq[$];
   string      nameq[$];
   logic [7:0] mon_exp;
   string      mon_nm;

   logic [7:0] lexp[8] = '{8'h66, 8'hCC, 8'h98, 8'h30,
                           8'h60, 8'hC0, 8'h80, 8'h00};
   logic [7:0] rexp[8] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F,
                           8'h0F, 8'h07, 8'h03, 8'h01};

   barrel_shifter #(.WIDTH(8), .SHW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .shamt (shamt),
      .dir   (dir),
      .out   (out)
   );

   // free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [7:0] act,
                        input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: out=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [2:0] s,
                       input logic dr, input logic [7:0] e,
                       input string nm);
      @(negedge clk);
      in    = d;
      shamt = s;
      dir   = dr;
      expq.push_back(rst_n ? e : 8'h00);
      nameq.push_back(nm);
   endtask

   // monitor: one result per rising edge, compared just after the edge
   always @(posedge clk) begin
      #1;
      if (expq.size() != 0) begin
         mon_exp = expq.pop_front();
         mon_nm  = nameq.pop_front();
         check(mon_nm, out, mon_exp);
      end
   end

   initial begin
      #2 rst_n = 1'b0;
      #1 check("async_reset", out, 8'h00);

      for (int i = 0; i < 3; i++)
         send(8'hFF, 3'd0, 1'b0, 8'hFF, "reset_hold");
      @(posedge clk);
      #3 rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         send(8'h66, 3'(i), 1'b1, lexp[i], $sformatf("left_sh%0d", i));

      for (int i = 0; i < 8; i++)
         send(8'hFF, 3'(i), 1'b0, rexp[i], $sformatf("right_sh%0d", i));

      send(8'h00, 3'd3, 1'b1, 8'h00, "zero_l3");
      send(8'h00, 3'd5, 1'b0, 8'h00, "zero_r5");
      send(8'h00, 3'd7, 1'b1, 8'h00, "zero_l7");

      send(8'h01, 3'd7, 1'b1, 8'h80, "walk_l7");
      send(8'h80, 3'd7, 1'b0, 8'h01, "walk_r7");
      send(8'h80, 3'd1, 1'b1, 8'h00, "walk_l1_out");
      send(8'hA5, 3'd0, 1'b1, 8'hA5, "pass_l0");
      send(8'hA5, 3'd0, 1'b0, 8'hA5, "pass_r0");

      send(8'h81, 3'd2, 1'b0, 8'h20, "sample_r2");
      @(posedge clk);
      #2;
      in    = 8'hFF;
      shamt = 3'd0;
      #2 check("between_edges", out, 8'h20);

      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            @(posedge clk);
            #3 rst_n = 1'b0;
            #1 check("midrun_reset", out, 8'h00);
            send(8'h66, 3'(i), 1'b1, lexp[i], "midrun_hold");
            @(posedge clk);
            #3 rst_n = 1'b1;
         end
         send(8'h66, 3'(i), 1'b1, lexp[i], $sformatf("midrun_sh%0d", i));
      end

      for (int k = 0; k < 10 && expq.size() != 0; k++)
         @(posedge clk);
      #2;
      if (expq.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d results pending, expected 0",
                  expq.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
